// File: rtl/sng_bank_et.sv
// sng_bank_et -- stochastic-number-generator bank feeding a 4-input
// Roberts-cross (RCED) core.
//
// Four WIDTH-bit binary operands are turned into four bitstreams that all
// compare against one shared LFSR value, so the streams are maximally
// correlated (SCC=+1) and a downstream XOR of two streams yields |a-b|.
// A 0.5-probability select stream c is produced alongside.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (sampled only in IDLE)
//   abort      : end the current run early (sampled only in RUN, on a valid beat)
//   len        : run length in beats, WIDTH+1 bits; 0 or > period selects a full period
//   Bxs        : four packed WIDTH-bit operands, channel i at Bxs[i*WIDTH +: WIDTH]
//   Xs         : one stochastic bit per channel, Xs[i] = (Bx_i > R)
//   c          : select stream, toggles with the beat number (first beat c=1)
//   valid      : Xs/c carry a beat this cycle
//   last       : final beat of a length-complete run
//   busy       : run in progress
//
// Build option
//   LFSR_ZERO_INS_EN : de Bruijn zero insertion; period becomes 2^WIDTH and a
//                      full run yields exactly Bx_i ones per channel.
module sng_bank_et #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH:0]       len,
    input  logic [4*WIDTH-1:0]   Bxs,
    output logic [3:0]           Xs,
    output logic                 c,
    output logic                 valid,
    output logic                 last,
    output logic                 busy
);

`ifdef LFSR_ZERO_INS_EN
    localparam int unsigned PERIOD = 2 ** WIDTH;
`else
    localparam int unsigned PERIOD = 2 ** WIDTH - 1;
`endif
    localparam logic [WIDTH:0] P_LEN = (WIDTH+1)'(PERIOD);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH:0]       cnt_q, cnt_d;
    logic [WIDTH:0]       l_q, l_d;
    logic [4*WIDTH-1:0]   bx_q, bx_d;
    logic [3:0]           xs_q, xs_d;
    logic                 c_q, c_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [WIDTH:0]       cnt_inc;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] n;
        n = (r >> 1) ^ (r[0] ? POLY : '0);
`ifdef LFSR_ZERO_INS_EN
        // Splice the all-zero state in between 1 and POLY.
        if (r == WIDTH'(1)) begin
            n = '0;
        end else if (r == '0) begin
            n = POLY;
        end
`endif
        return n;
    endfunction

    assign cnt_inc = cnt_q + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        bx_d    = bx_q;
        xs_d    = '0;
        c_d     = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bx_d    = Bxs;
                    l_d     = (len == '0 || len > P_LEN) ? P_LEN : len;
                    r_d     = SEED;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The beat on the outputs is the final one; no new beat follows.
                // On a last beat the FSM is already back in IDLE, so an abort
                // there is never seen and the run completes normally.
                if (abort && valid_q) begin
                    state_d = IDLE;
                end else begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        xs_d[i] = bx_q[i*WIDTH +: WIDTH] > r_q;
                    end
                    c_d     = cnt_inc[0];
                    valid_d = 1'b1;
                    r_d     = lfsr_next(r_q);
                    cnt_d   = cnt_inc;
                    if (cnt_inc == l_q) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= SEED;
            cnt_q   <= '0;
            l_q     <= '0;
            bx_q    <= '0;
            xs_q    <= '0;
            c_q     <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            bx_q    <= bx_d;
            xs_q    <= xs_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign Xs    = xs_q;
    assign c     = c_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_sng_bank_et.sv
module tb_sng_bank_et;

`ifdef LFSR_ZERO_INS_EN
    localparam int P      = 256;
    localparam int HALF   = 128;
    localparam int Q1     = 64;
    localparam int Q3     = 192;
    localparam int FULLFF = 255;
    localparam logic [4:0] BEAT2 = 5'b01111;
`else
    localparam int P      = 255;
    localparam int HALF   = 127;
    localparam int Q1     = 63;
    localparam int Q3     = 191;
    localparam int FULLFF = 254;
    localparam logic [4:0] BEAT2 = 5'b00110;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  len = '0;
    logic [31:0] Bxs = '0;
    logic [3:0]  Xs;
    logic        c, valid, last, busy;

    int vectors = 0;
    int errors  = 0;

    int  beats, last_cnt, last_beat, ones_c, corr_err;
    int  ones [4];
    logic busy_after;
    bit  timeout;
    logic [4:0] stream [0:299];
    logic [4:0] ref_stream [0:19];

    always #5 clk = ~clk;

    sng_bank_et #(
        .WIDTH(8),
        .POLY (8'hB8),
        .SEED (8'h01)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .len  (len),
        .Bxs  (Bxs),
        .Xs   (Xs),
        .c    (c),
        .valid(valid),
        .last (last),
        .busy (busy)
    );

    // Launches one run and gathers per-beat statistics; checking is left to the callers.
    task automatic do_run(input logic [8:0] l, input logic [31:0] b, input int abort_at,
                          input bit noise, input bit abort_with_start);
        beats = 0; last_cnt = 0; last_beat = 0; ones_c = 0; corr_err = 0;
        for (int i = 0; i < 4; i++) ones[i] = 0;
        busy_after = 1'b1;
        timeout = 1'b1;
        @(negedge clk);
        start = 1'b1; len = l; Bxs = b; abort = abort_with_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; len = 9'h0AA; Bxs = 32'h5A5A_5A5A;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (valid) begin
                if (beats < 300) stream[beats] = {c, Xs};
                beats++;
                for (int i = 0; i < 4; i++) ones[i] += int'(Xs[i]);
                ones_c += int'(c);
                if (Xs[0] != Xs[3] || Xs[1] != Xs[2]) corr_err++;
                if (last) begin
                    last_cnt++;
                    last_beat = beats;
                end
                if (beats == abort_at) abort = 1'b1;
                if (noise && beats >= 3 && beats <= 6) start = 1'b1;
            end else if (beats > 0) begin
                busy_after = busy;
                timeout = 1'b0;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        Bxs = b;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (Xs !== 4'b0)   begin errors++; $display("FAIL reset_xs: got %b expected 0000", Xs); end
        vectors++; if (c !== 1'b0)    begin errors++; $display("FAIL reset_c: got %b expected 0", c); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        vectors++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_beats;
        do_run(9'd3, 32'h40C0_C040, 0, 1'b0, 1'b0);
        vectors++; if (timeout) begin errors++; $display("FAIL first_timeout: got beats %0d expected run end", beats); end
        vectors++; if (beats !== 3) begin errors++; $display("FAIL first_beats: got %0d expected 3", beats); end
        vectors++; if (stream[0] !== 5'b11111) begin errors++; $display("FAIL first_beat1: got %b expected 11111", stream[0]); end
        vectors++; if (stream[1] !== BEAT2) begin errors++; $display("FAIL first_beat2: got %b expected %b", stream[1], BEAT2); end
        vectors++; if (stream[2] !== 5'b10110) begin errors++; $display("FAIL first_beat3: got %b expected 10110", stream[2]); end
        vectors++; if (last_beat !== 3) begin errors++; $display("FAIL first_last: got %0d expected 3", last_beat); end
    endtask

    task automatic test_full_half;
        do_run(9'd0, 32'h8080_8080, 0, 1'b0, 1'b0);
        vectors++; if (timeout) begin errors++; $display("FAIL half_timeout: got beats %0d expected run end", beats); end
        vectors++; if (beats !== P) begin errors++; $display("FAIL half_beats: got %0d expected %0d", beats, P); end
        vectors++; if (last_cnt !== 1 || last_beat !== P) begin errors++; $display("FAIL half_last: got %0d at beat %0d expected 1 at %0d", last_cnt, last_beat, P); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (ones[i] !== HALF) begin errors++; $display("FAIL half_ones%0d: got %0d expected %0d", i, ones[i], HALF); end
        end
        vectors++; if (ones_c !== 128) begin errors++; $display("FAIL half_c_ones: got %0d expected 128", ones_c); end
        vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL half_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_correlation;
        do_run(9'd0, 32'h40C0_C040, 0, 1'b0, 1'b0);
        vectors++; if (timeout) begin errors++; $display("FAIL corr_timeout: got beats %0d expected run end", beats); end
        vectors++; if (corr_err !== 0) begin errors++; $display("FAIL corr_pairs: got %0d unequal beats expected 0", corr_err); end
        vectors++; if (ones[0] !== Q1) begin errors++; $display("FAIL corr_ones40: got %0d expected %0d", ones[0], Q1); end
        vectors++; if (ones[1] !== Q3) begin errors++; $display("FAIL corr_onesC0: got %0d expected %0d", ones[1], Q3); end
    endtask

    task automatic test_extremes;
        // len above the period clamps to a full run
        do_run(9'h1FF, 32'hFF00_FF00, 0, 1'b0, 1'b0);
        vectors++; if (timeout) begin errors++; $display("FAIL ext_timeout: got beats %0d expected run end", beats); end
        vectors++; if (beats !== P) begin errors++; $display("FAIL ext_beats: got %0d expected %0d", beats, P); end
        vectors++; if (ones[0] !== 0 || ones[2] !== 0) begin errors++; $display("FAIL ext_ones00: got %0d/%0d expected 0", ones[0], ones[2]); end
        vectors++; if (ones[1] !== FULLFF || ones[3] !== FULLFF) begin errors++; $display("FAIL ext_onesFF: got %0d/%0d expected %0d", ones[1], ones[3], FULLFF); end
    endtask

    task automatic test_len16;
        // abort alongside start is ignored; start pulses mid-run are ignored
        do_run(9'd16, 32'h8080_8080, 0, 1'b1, 1'b1);
        vectors++; if (timeout) begin errors++; $display("FAIL len16_timeout: got beats %0d expected run end", beats); end
        vectors++; if (beats !== 16) begin errors++; $display("FAIL len16_beats: got %0d expected 16", beats); end
        vectors++; if (last_cnt !== 1 || last_beat !== 16) begin errors++; $display("FAIL len16_last: got %0d at beat %0d expected 1 at 16", last_cnt, last_beat); end
        vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL len16_busy_after: got %b expected 0", busy_after); end
        vectors++; if (ones_c !== 8) begin errors++; $display("FAIL len16_c_ones: got %0d expected 8", ones_c); end
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL len16_idle: got busy %b valid %b expected 0 0", busy, valid); end
    endtask

    task automatic test_abort;
        do_run(9'd0, 32'h8080_8080, 5, 1'b0, 1'b0);
        vectors++; if (timeout) begin errors++; $display("FAIL abort_timeout: got beats %0d expected run end", beats); end
        vectors++; if (beats !== 5) begin errors++; $display("FAIL abort_beats: got %0d expected 5", beats); end
        vectors++; if (last_cnt !== 0) begin errors++; $display("FAIL abort_last: got %0d expected 0", last_cnt); end
        vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_reset_midrun;
        int diff;
        do_run(9'd20, 32'h1F9A_63E4, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) ref_stream[i] = stream[i];
        @(negedge clk);
        start = 1'b1; len = 9'd20; Bxs = 32'h1F9A_63E4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        vectors++; if (valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_running: got valid %b busy %b expected 1 1", valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({Xs, c, valid, last, busy} !== 8'b0) begin errors++; $display("FAIL mid_async_clear: got %b expected 00000000", {Xs, c, valid, last, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        do_run(9'd20, 32'h1F9A_63E4, 0, 1'b0, 1'b0);
        vectors++; if (beats !== 20) begin errors++; $display("FAIL mid_replay_beats: got %0d expected 20", beats); end
        diff = 0;
        for (int i = 0; i < 20; i++) if (stream[i] !== ref_stream[i]) diff++;
        vectors++; if (diff !== 0) begin errors++; $display("FAIL mid_replay_stream: got %0d differing beats expected 0", diff); end
    endtask

    initial begin
        test_reset();
        test_first_beats();
        test_full_half();
        test_correlation();
        test_extremes();
        test_len16();
        test_abort();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
